// File: rtl/kbd_report_decoder_if.sv
// rtl/kbd_report_decoder_if.sv - byte/char handshake bundle for kbd_report_decoder
//
// Signals:
//   rx_valid   one-cycle strobe: rx_data holds a new byte from the SPI slave
//   rx_data    received byte
//   char_data  ASCII character at the FIFO head
//   char_valid FIFO not empty
//   char_ready consumer accepts char_data when char_valid && char_ready
//
// Modports:
//   slave  - decoder side (consumes bytes, produces chars)
//   master - environment side (produces bytes, consumes chars)

interface kbd_report_decoder_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  char_ready,
        output char_data,
        output char_valid
    );

    modport master (
        output rx_valid,
        output rx_data,
        output char_ready,
        input  char_data,
        input  char_valid
    );
endinterface

// File: rtl/kbd_report_decoder.sv
// rtl/kbd_report_decoder.sv - HID boot-keyboard report parser, new-key detect, ASCII FIFO
//
// Parses framed boot-keyboard reports (cmd, modifier, reserved, key0..key5)
// arriving from the SPI slave, emits ASCII for newly pressed keys into a
// first-word-fall-through FIFO, and reports {ovf, caps, count} as status.
//
// Optional feature macro: KBD_CAPSLOCK_EN (usage 0x39 toggles caps lock).
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   spi_ss    raw SPI slave select (active low, asynchronous)
//   ovf_clr   one-cycle pulse clearing the sticky overflow flag
//   bus       kbd_report_decoder_if.slave: rx_valid/rx_data in,
//             char_data/char_valid out, char_ready in
//   status    {ovf, caps, count[5:0]}
//   caps_led  caps-lock state

module kbd_report_decoder #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] CMD_KBD    = 8'h01
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_ss,
    input  logic                 ovf_clr,
    kbd_report_decoder_if.slave  bus,
    output logic [7:0]           status,
    output logic                 caps_led
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [5:0] DEPTH_C = 6'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, SCAN, COMMIT} state_t;

    // ------------------------------------------------------------------
    // spi_ss synchroniser and edge detect (idle level is high)
    // ------------------------------------------------------------------
    logic ss_meta, ss_sync, ss_prev;
    logic frame_start, frame_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_meta <= 1'b1;
            ss_sync <= 1'b1;
            ss_prev <= 1'b1;
        end else begin
            ss_meta <= spi_ss;
            ss_sync <= ss_meta;
            ss_prev <= ss_sync;
        end
    end

    assign frame_start = ss_prev & ~ss_sync;
    assign frame_end   = ~ss_prev & ss_sync;

    // ------------------------------------------------------------------
    // Byte receiver. Only shift/ctrl are kept from the modifier byte.
    // key5 is never stored: it is byte8 itself and is taken from rx_data
    // in the cycle the report completes.
    // ------------------------------------------------------------------
    logic       frame_active;
    logic       cmd_ok;
    logic [3:0] byte_idx;
    logic       rx_shift, rx_ctrl;
    logic [7:0] rx_key [5];
    logic       rx_take;
    logic       frame_done;
    logic       rollover;

    assign rx_take = bus.rx_valid && frame_active && !frame_start && !frame_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_active <= 1'b0;
            cmd_ok       <= 1'b0;
            byte_idx     <= 4'd0;
            rx_shift     <= 1'b0;
            rx_ctrl      <= 1'b0;
            for (int i = 0; i < 5; i++) rx_key[i] <= 8'h00;
        end else if (frame_start) begin
            frame_active <= 1'b1;
            cmd_ok       <= 1'b0;
            byte_idx     <= 4'd0;
        end else if (frame_end) begin
            frame_active <= 1'b0;
        end else if (rx_take) begin
            // Saturate past byte8 so trailing bytes are ignored.
            if (byte_idx != 4'd9) byte_idx <= byte_idx + 4'd1;
            case (byte_idx)
                4'd0: cmd_ok <= (bus.rx_data == CMD_KBD);
                4'd1: if (cmd_ok) begin
                    rx_shift <= bus.rx_data[1] | bus.rx_data[5];
                    rx_ctrl  <= bus.rx_data[0] | bus.rx_data[4];
                end
                4'd3: if (cmd_ok) rx_key[0] <= bus.rx_data;
                4'd4: if (cmd_ok) rx_key[1] <= bus.rx_data;
                4'd5: if (cmd_ok) rx_key[2] <= bus.rx_data;
                4'd6: if (cmd_ok) rx_key[3] <= bus.rx_data;
                4'd7: if (cmd_ok) rx_key[4] <= bus.rx_data;
                default: ;
            endcase
        end
    end

    assign frame_done = rx_take && cmd_ok && (byte_idx == 4'd8);

    always_comb begin
        rollover = (bus.rx_data == 8'h01);
        for (int i = 0; i < 5; i++) rollover = rollover && (rx_key[i] == 8'h01);
    end

    // ------------------------------------------------------------------
    // Scan datapath
    // ------------------------------------------------------------------
    state_t     state, state_n;
    logic       load_scan, commit, push_req;
    logic [7:0] scan_key [6];
    logic [7:0] prev_key [6];
    logic       scan_shift, scan_ctrl;
    logic [2:0] scan_idx;
    logic [7:0] cur_key;
    logic       key_new;
    logic [8:0] map_res;
    logic       caps;

    always_comb begin
        cur_key = 8'h00;
        case (scan_idx)
            3'd0: cur_key = scan_key[0];
            3'd1: cur_key = scan_key[1];
            3'd2: cur_key = scan_key[2];
            3'd3: cur_key = scan_key[3];
            3'd4: cur_key = scan_key[4];
            3'd5: cur_key = scan_key[5];
            default: cur_key = 8'h00;
        endcase
    end

    always_comb begin
        key_new = (cur_key != 8'h00);
        for (int i = 0; i < 6; i++) key_new = key_new && (prev_key[i] != cur_key);
    end

    // Returns {mapped, ascii}; mapped=0 for usages that produce no char.
    function automatic logic [8:0] map_usage(input logic [7:0] u, input logic shift,
                                             input logic ctrl, input logic caps_on);
        logic [7:0] off;
        off       = u - 8'h04;
        map_usage = 9'h000;
        if (u >= 8'h04 && u <= 8'h1D) begin
            if (ctrl)                 map_usage = {1'b1, off + 8'h01};
            else if (shift ^ caps_on) map_usage = {1'b1, off + 8'h41};
            else                      map_usage = {1'b1, off + 8'h61};
        end else if (u >= 8'h1E && u <= 8'h27) begin
            if (shift) begin
                case (u)
                    8'h1E: map_usage = {1'b1, 8'h21};
                    8'h1F: map_usage = {1'b1, 8'h40};
                    8'h20: map_usage = {1'b1, 8'h23};
                    8'h21: map_usage = {1'b1, 8'h24};
                    8'h22: map_usage = {1'b1, 8'h25};
                    8'h23: map_usage = {1'b1, 8'h5E};
                    8'h24: map_usage = {1'b1, 8'h26};
                    8'h25: map_usage = {1'b1, 8'h2A};
                    8'h26: map_usage = {1'b1, 8'h28};
                    default: map_usage = {1'b1, 8'h29};
                endcase
            end else if (u == 8'h27) begin
                map_usage = {1'b1, 8'h30};
            end else begin
                map_usage = {1'b1, u + 8'h13};
            end
        end else begin
            case (u)
                8'h28: map_usage = {1'b1, 8'h0D};
                8'h29: map_usage = {1'b1, 8'h1B};
                8'h2A: map_usage = {1'b1, 8'h08};
                8'h2B: map_usage = {1'b1, 8'h09};
                8'h2C: map_usage = {1'b1, 8'h20};
                default: map_usage = 9'h000;
            endcase
        end
    endfunction

    assign map_res = map_usage(cur_key, scan_shift, scan_ctrl, caps);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

`ifdef KBD_CAPSLOCK_EN
    logic caps_toggle;
`endif

    always_comb begin
        state_n   = state;
        load_scan = 1'b0;
        commit    = 1'b0;
        push_req  = 1'b0;
`ifdef KBD_CAPSLOCK_EN
        caps_toggle = 1'b0;
`endif
        case (state)
            IDLE: if (frame_start) state_n = RECV;
            RECV: begin
                // A rollover report is dropped whole; the table stays as it was.
                if (frame_done) begin
                    if (rollover) begin
                        state_n = IDLE;
                    end else begin
                        load_scan = 1'b1;
                        state_n   = SCAN;
                    end
                end
            end
            SCAN: begin
                push_req = key_new && map_res[8];
`ifdef KBD_CAPSLOCK_EN
                caps_toggle = key_new && (cur_key == 8'h39);
`endif
                if (scan_idx == 3'd5) state_n = COMMIT;
            end
            COMMIT: begin
                commit  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_idx   <= 3'd0;
            scan_shift <= 1'b0;
            scan_ctrl  <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                scan_key[i] <= 8'h00;
                prev_key[i] <= 8'h00;
            end
        end else begin
            if (load_scan) begin
                for (int i = 0; i < 5; i++) scan_key[i] <= rx_key[i];
                scan_key[5] <= bus.rx_data;
                scan_shift  <= rx_shift;
                scan_ctrl   <= rx_ctrl;
                scan_idx    <= 3'd0;
            end else if (state == SCAN) begin
                scan_idx <= scan_idx + 3'd1;
            end
            if (commit) begin
                for (int i = 0; i < 6; i++) prev_key[i] <= scan_key[i];
            end
        end
    end

`ifdef KBD_CAPSLOCK_EN
    // Toggled at the scan cycle of 0x39, so later letters in the same
    // report already see the new state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            caps <= 1'b0;
        else if (caps_toggle) caps <= ~caps;
    end
`else
    assign caps = 1'b0;
`endif

    assign caps_led = caps;

    // ------------------------------------------------------------------
    // Character FIFO with registered head (first word fall through)
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
    logic [5:0]    count, count_n, remain;
    logic [7:0]    head_q, head_n;
    logic          ovf;
    logic          do_pop, do_push, full, ovf_set;

    assign full    = (count == DEPTH_C);
    assign do_pop  = (count != 6'd0) && bus.char_ready;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_push = push_req && (!full || do_pop);
    assign ovf_set = push_req && full && !do_pop;
    assign count_n = count + 6'(do_push) - 6'(do_pop);
    assign rd_n    = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    assign remain  = count - 6'(do_pop);

    always_comb begin
        head_n = head_q;
        if (do_push && remain == 6'd0) head_n = map_res[7:0];
        else if (count_n != 6'd0)      head_n = mem[rd_n];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= map_res[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 6'd0;
            head_q <= 8'h00;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_n;
            count  <= count_n;
            head_q <= head_n;
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    assign bus.char_data  = head_q;
    assign bus.char_valid = (count != 6'd0);
    assign status         = {ovf, caps, count};

endmodule

// File: doc/kbd_report_decoder.md
Name: kbd_report_decoder

Overview:
- Consumes the byte stream delivered by the MCU SPI slave: per-byte data plus a one-cycle clk-domain strobe.
- Parses framed USB HID boot-keyboard reports and detects newly pressed keys.
- Translates those keys to ASCII and queues them in a FIFO for the terminal input path.
- Returns a status byte that the SPI slave shifts back to the MCU as its reply data.

Parameters:
- FIFO_DEPTH, 8, character FIFO entries; power of 2, range 2..32.
- CMD_KBD, 8'h01, frame command byte identifying a keyboard report.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- spi_ss  in  1  raw SPI slave select, active low, asynchronous; synchronised internally with 2 flops.
- rx_valid  in  1  one-cycle strobe, clk domain: rx_data holds a new byte.
- rx_data  in  8  received byte.
- ovf_clr  in  1  one-cycle pulse; clears the sticky overflow flag.
- char_data  out  8  ASCII character at the FIFO head.
- char_valid  out  1  FIFO not empty.
- char_ready  in  1  consumer accepts char_data when char_valid && char_ready.
- status  out  8  {ovf, caps, count[5:0]}; fed to the SPI slave reply input.
- caps_led  out  1  caps-lock state.

Behaviour:
- Reset values: char_valid=0, char_data=0, status=0, caps_led=0. FIFO empty, previous-key table all 0x00, state IDLE.
- Frame start: a falling edge of the synchronised spi_ss resets byte index to 0 and discards any partial frame.
- Frame layout: byte0 = command; bytes1..8 = modifier, reserved, key0..key5.
- If byte0 != CMD_KBD, all further bytes are ignored until the next frame start.
- Bytes after byte8 are ignored.
- Early end: if spi_ss rises before byte8, the frame is discarded and the previous-key table is unchanged.
- States:
  - IDLE -> RECV on frame start.
  - RECV -> SCAN on receipt of byte8. At this point the 6 keys and modifier are copied into scan registers.
  - SCAN steps idx 0..5, one key per clk.
  - SCAN -> COMMIT after idx 5. COMMIT copies the scan keys into the previous-key table, then -> IDLE.
- A new frame may be received while SCAN/COMMIT is active; only the receive registers are used.
- If byte8 of a new frame arrives while not in RECV (i.e. SCAN/COMMIT still running), that frame is dropped.
- ErrorRollOver: if all six keys equal 0x01, the report is discarded with no chars emitted and the table unchanged.
- Key scan:
  - A key is "new" if it is nonzero and absent from all 6 previous-table entries (combinational compare).
  - Only new keys with a mapping are pushed; 1 push max per clk.
- Modifiers: shift = mod[1]|mod[5]; ctrl = mod[0]|mod[4].
- Usage-to-ASCII mapping:
  - 0x04-0x1D → 'a'-'z'. Uppercase if shift XOR caps.
  - Ctrl has priority on letters: ctrl+letter → 0x01-0x1A.
  - 0x1E-0x26 → '1'-'9'; 0x27 → '0'.
  - Shifted digits → "!@#$%^&*()" respectively.
  - 0x28 → 0x0D; 0x29 → 0x1B; 0x2A → 0x08; 0x2B → 0x09; 0x2C → 0x20.
  - All other usages are ignored.
- Latency: a char for scan idx i is pushed at cycle N+1+i, where N is the cycle the byte8 strobe is sampled. char_valid rises the cycle after the push. With an empty FIFO, the first char is visible 2 cycles after the byte8 strobe.
- FIFO:
  - Registered head output, FWFT.
  - count = 0..FIFO_DEPTH.
  - Push while full drops the char and sets ovf.
  - Simultaneous push and pop when full: the pop is accepted and the push is accepted, no overflow.
  - Simultaneous push and pop when empty: the push is stored and the pop is ignored (char_valid=0 that cycle).
- ovf: sticky; cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- reset mid-frame or mid-scan: all state returns to reset values immediately; no partial pushes survive.

Optional Feature:
- Macro: KBD_CAPSLOCK_EN.
- Defined:
  - A new usage 0x39 toggles caps at its scan cycle.
  - Letters scanned later in the same report see the updated caps.
  - caps_led = caps; 0x39 emits no char.
- Undefined:
  - 0x39 is ignored.
  - caps is tied 0, caps_led = 0, and status[6] = 0.

Test Plan:
- Basic press and release:
  - Frame 01,00,00,04,00,00,00,00,00 → char 0x61 ('a') with char_valid 2 cycles after the byte8 strobe.
  - Repeating the identical frame → no char.
  - Then frame 01 + all zeros → no char; the next 'a' frame emits 0x61 again.
- Modifiers:
  - Frame with mod=0x02 and keys 04,1E → chars 0x41, 0x21 in idx order.
  - Frame with mod=0x10 and key 06 → 0x03.
- Early end, rollover and bad command:
  - spi_ss rises after byte5 → no chars, table unchanged.
  - Frame with keys all 0x01 → no chars.
  - Command 0x02 frame → ignored.
- Overflow:
  - With char_ready=0, send 9 distinct new keys across 2 frames (FIFO_DEPTH=8) → count=8, ovf=1, status=0x88.
  - ovf_clr → status=0x08.
  - Drain → chars come out in push order.
- Reset and simultaneous events:
  - Assert reset during SCAN → char_valid=0, status=0x00.
  - Full FIFO with simultaneous push and pop → count stays 8, ovf stays 0.
- Caps lock (KBD_CAPSLOCK_EN defined):
  - Frame keys 39,04 → caps_led=1, char 0x41.
  - Macro undefined: same frame → caps_led=0, char 0x61.
